// File: rtl/clock_gate_ctrl.sv
// Multi-channel clock-gating controller: per-channel req/ack FSM with wake-up count,
// idle hysteresis and a glitch-free latch-based gating cell on each output clock.
module clock_gate_ctrl #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned WAKE_CYCLES = 2,
    parameter int unsigned IDLE_CYCLES = 8
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              test_pin,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] ack,
    output logic [NUM_CH-1:0] clk_out,
    output logic              busy
);

    localparam int unsigned MaxCnt = (WAKE_CYCLES > IDLE_CYCLES) ? WAKE_CYCLES : IDLE_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);
    localparam logic [CntW-1:0] WakeLast = CntW'(WAKE_CYCLES - 1);
    localparam logic [CntW-1:0] IdleLast = CntW'(IDLE_CYCLES - 1);

    typedef enum logic [1:0] {StOff, StWake, StOn, StHold} state_e;

    logic [NUM_CH-1:0] active_d;
    logic              busy_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_e          state_q, state_d;
        logic [CntW-1:0] cnt_q, cnt_d;
        logic            gate_en_q, gate_en_d;
        logic            ack_q, ack_d;
        logic            en_latch;

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            gate_en_d = gate_en_q;
            ack_d     = ack_q;
            unique case (state_q)
                StOff: begin
                    if (req[i]) begin
                        state_d   = StWake;
                        gate_en_d = 1'b1;
                        cnt_d     = '0;
                    end
                end
                // A wake always runs to completion; req only picks ON vs HOLD at the end.
                StWake: begin
                    if (cnt_q == WakeLast) begin
                        if (req[i]) begin
                            state_d = StOn;
                            ack_d   = 1'b1;
                        end else begin
                            state_d = StHold;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StOn: begin
                    if (!req[i]) begin
                        state_d = StHold;
                        ack_d   = 1'b0;
                        cnt_d   = '0;
                    end
                end
                StHold: begin
                    if (req[i]) begin
                        state_d = StOn;
                        ack_d   = 1'b1;
                    end else if (cnt_q == IdleLast) begin
                        state_d   = StOff;
                        gate_en_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_d   = StOff;
                    cnt_d     = '0;
                    gate_en_d = 1'b0;
                    ack_d     = 1'b0;
                end
            endcase
        end

        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= StOff;
                cnt_q     <= '0;
                gate_en_q <= 1'b0;
                ack_q     <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                gate_en_q <= gate_en_d;
                ack_q     <= ack_d;
            end
        end

        // Transparent only while clk_in is low, so enable changes never cut a high phase.
        always_latch begin
            if (!rst_n) begin
                en_latch = 1'b0;
            end else if (!clk_in) begin
                en_latch = gate_en_q | test_pin;
            end
        end

        assign clk_out[i]  = clk_in & en_latch;
        assign ack[i]      = ack_q;
        assign active_d[i] = (state_d != StOff);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= |active_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Randomised and directed bench for clock_gate_ctrl against a countdown-based reference model.
module tb_clock_gate_ctrl;

    localparam int NCH  = 4;
    localparam int WAKE = 2;
    localparam int IDLE = 8;

    logic           clk_in = 1'b0;
    logic           rst_n;
    logic           test_pin;
    logic [NCH-1:0] req;
    logic [NCH-1:0] ack;
    logic [NCH-1:0] clk_out;
    logic           busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a channel is "clocked" (m_gate) from request until its idle countdown
    // expires; wake_left counts edges still owed before ack may rise.
    logic [NCH-1:0] m_gate;
    logic [NCH-1:0] m_ack;
    int             wake_left [NCH];
    int             idle_left [NCH];
    int             edge_cnt  [NCH];

    clock_gate_ctrl #(
        .NUM_CH     (NCH),
        .WAKE_CYCLES(WAKE),
        .IDLE_CYCLES(IDLE)
    ) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .test_pin(test_pin),
        .req     (req),
        .ack     (ack),
        .clk_out (clk_out),
        .busy    (busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NCH; g++) begin : g_mon
        time t_rise = 0;
        always @(posedge clk_out[g]) begin
            t_rise = $time;
            edge_cnt[g]++;
        end
        always @(negedge clk_out[g]) begin
            if (rst_n) check("glitch", int'(($time - t_rise) >= 5), 1);
        end
    end

    function automatic void model_clear();
        m_gate = '0;
        m_ack  = '0;
        for (int c = 0; c < NCH; c++) begin
            wake_left[c] = 0;
            idle_left[c] = 0;
        end
    endfunction

    function automatic void model_step(input logic [NCH-1:0] r);
        for (int c = 0; c < NCH; c++) begin
            if (!m_gate[c]) begin
                if (r[c]) begin
                    m_gate[c]    = 1'b1;
                    wake_left[c] = WAKE;
                end
            end else if (wake_left[c] > 0) begin
                wake_left[c]--;
                if (wake_left[c] == 0) begin
                    if (r[c]) m_ack[c] = 1'b1;
                    else      idle_left[c] = IDLE;
                end
            end else if (m_ack[c]) begin
                if (!r[c]) begin
                    m_ack[c]     = 1'b0;
                    idle_left[c] = IDLE;
                end
            end else if (r[c]) begin
                m_ack[c] = 1'b1;
            end else begin
                idle_left[c]--;
                if (idle_left[c] == 0) m_gate[c] = 1'b0;
            end
        end
    endfunction

    // One clk_in period whose rising edge samples nreq; entered and left in the low phase.
    task automatic cycle(input logic [NCH-1:0] nreq, input logic ntp);
        logic [NCH-1:0] exp_clk;
        req      = nreq;
        test_pin = ntp;
        exp_clk  = m_gate | {NCH{ntp}};
        @(posedge clk_in);
        #1;
        check("clk_high", int'(clk_out), int'(exp_clk));
        model_step(nreq);
        check("ack", int'(ack), int'(m_ack));
        check("busy", int'(busy), int'(|m_gate));
        @(negedge clk_in);
        #1;
        check("clk_low", int'(clk_out), 0);
    endtask

    task automatic do_reset();
        @(posedge clk_in);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_ack", int'(ack), 0);
        check("rst_clk", int'(clk_out), 0);
        check("rst_busy", int'(busy), 0);
        model_clear();
        @(posedge clk_in);
        #1;
        check("rst_hold_clk", int'(clk_out), 0);
        rst_n = 1'b1;
        @(negedge clk_in);
        #1;
    endtask

    function automatic void clear_edges();
        for (int c = 0; c < NCH; c++) edge_cnt[c] = 0;
    endfunction

    initial begin
        logic [NCH-1:0] rq;
        for (int c = 0; c < NCH; c++) edge_cnt[c] = 0;
        model_clear();
        rst_n    = 1'b0;
        test_pin = 1'b0;
        req      = '1;
        #3;
        check("por_ack", int'(ack), 0);
        check("por_busy", int'(busy), 0);
        check("por_clk", int'(clk_out), 0);
        @(posedge clk_in);
        #1;
        check("por_clk_hi", int'(clk_out), 0);
        req   = '0;
        rst_n = 1'b1;
        @(negedge clk_in);
        #1;

        // Idle after reset: no clock edges at all.
        clear_edges();
        repeat (20) cycle('0, 1'b0);
        check("idle_edges", edge_cnt[0] + edge_cnt[1] + edge_cnt[2] + edge_cnt[3], 0);

        // Wake on ch0: two gated edges before ack.
        clear_edges();
        cycle(4'b0001, 1'b0);
        check("wake_busy", int'(busy), 1);
        check("wake_e0_edges", edge_cnt[0], 0);
        cycle(4'b0001, 1'b0);
        check("wake_e1_ack", int'(ack[0]), 0);
        cycle(4'b0001, 1'b0);
        check("wake_e2_ack", int'(ack[0]), 1);
        check("wake_edges", edge_cnt[0], 2);
        check("wake_others", edge_cnt[1] + edge_cnt[2] + edge_cnt[3], 0);

        // Idle hysteresis on ch1 (ch0 released at the same edge).
        repeat (3) cycle(4'b0011, 1'b0);
        check("on_ack", int'(ack), 32'h3);
        cycle('0, 1'b0);
        check("rel_ack", int'(ack[1]), 0);
        clear_edges();
        repeat (7) cycle('0, 1'b0);
        check("rel_busy_r7", int'(busy), 1);
        cycle('0, 1'b0);
        check("rel_busy_r8", int'(busy), 0);
        repeat (4) cycle('0, 1'b0);
        check("rel_edges", edge_cnt[1], IDLE);

        // Re-request ch2 from HOLD: ack back after one edge, clock never interrupted.
        repeat (3) cycle(4'b0100, 1'b0);
        cycle('0, 1'b0);
        clear_edges();
        cycle('0, 1'b0);
        cycle('0, 1'b0);
        cycle(4'b0100, 1'b0);
        check("hold_rereq_ack", int'(ack[2]), 1);
        check("hold_edges", edge_cnt[2], 3);
        repeat (12) cycle('0, 1'b0);

        // Wake abort attempt on ch3.
        cycle(4'b1000, 1'b0);
        cycle('0, 1'b0);
        cycle('0, 1'b0);
        check("abort_ack", int'(ack[3]), 0);
        clear_edges();
        repeat (12) cycle('0, 1'b0);
        check("abort_edges", edge_cnt[3], IDLE);

        // test_pin forces all clocks, FSMs untouched.
        clear_edges();
        repeat (5) cycle('0, 1'b1);
        check("tp_edges", edge_cnt[0] + edge_cnt[1] + edge_cnt[2] + edge_cnt[3], 4 * 5);
        cycle('0, 1'b0);

        // Reset while ch0 is ON.
        repeat (4) cycle(4'b0001, 1'b0);
        check("pre_rst_ack", int'(ack[0]), 1);
        do_reset();

        // Random traffic with sticky per-channel requests and occasional test_pin / reset.
        rq = '0;
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 5) == 0) rq[c] = ~rq[c];
            end
            if ($urandom_range(0, 299) == 0) do_reset();
            cycle(rq, $urandom_range(0, 19) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clock_gate_ctrl.md
# clock_gate_ctrl

Multi-channel clock-gating controller and the parametrised successor to `clock_gate`. It provides `NUM_CH` independently gated copies of `clk_in`, each driven by a per-channel req/ack handshake. A channel's clock is ungated on request, `ack` asserts after a fixed wake-up count of delivered edges, and the clock is re-gated only after an idle hysteresis window. It sits between the shared SPI clock root and the SPI sub-blocks (shifter, CS sequencer, FIFOs), so idle sub-blocks receive no clock edges.

## Interface
- `NUM_CH`, 4, number of gated channels (≥1)
- `WAKE_CYCLES`, 2, gated rising edges delivered before `ack` asserts (≥1)
- `IDLE_CYCLES`, 8, clk_in cycles a channel stays ungated after `req` falls (≥1)

- `clk_in`  input  1  free-running source clock; all state updates on its rising edge
- `rst_n`  input  1  asynchronous, active-low reset; deassertion synchronous to `clk_in` (external synchroniser)
- `test_pin`  input  1  scan/test override; forces all `clk_out` running
- `req`  input  NUM_CH  per-channel clock request, level, synchronous to `clk_in`
- `ack`  output  NUM_CH  per-channel clock-running acknowledge
- `clk_out`  output  NUM_CH  gated clocks
- `busy`  output  1  high when any channel is not in OFF

## Operation
- Per-channel FSM, states OFF, WAKE, ON, HOLD. Per-channel counter width is `$clog2(max(WAKE_CYCLES,IDLE_CYCLES)+1)`. Each channel registers `gate_en`.
- OFF: `gate_en`=0, `ack`=0.
  - `req`=1 sampled → WAKE, `gate_en`<=1, cnt<=0.
- WAKE: `req` is ignored for transition purposes; a wake is never aborted.
  - cnt increments each edge.
  - Edge with cnt==WAKE_CYCLES-1: go to ON with `ack`<=1 if `req`=1; otherwise go to HOLD with cnt<=0 and `ack` stays 0.
- ON: `ack`=1, `gate_en`=1.
  - `req`=0 sampled → HOLD, `ack`<=0, cnt<=0.
- HOLD: `gate_en`=1, `ack`=0.
  - `req`=1 → ON, `ack`<=1 on the same edge, with no wake delay.
  - Else if cnt==IDLE_CYCLES-1 → OFF, `gate_en`<=0.
  - Else cnt++.
- Gating cell per channel: a latch transparent while `clk_in`=0 captures `gate_en | test_pin`, and `clk_out[i]` = `clk_in` & latch. This guarantees no glitches and no truncated high phases.
- `test_pin`=1 makes every `clk_out` follow `clk_in` (subject to the latch). FSMs, `ack` and `busy` are unaffected by `test_pin`.
- `busy` = OR over channels of (state≠OFF), registered.
- Channels are fully independent, and simultaneous events on different channels do not interact.

## Timing
- Reset (asynchronous): every channel goes to OFF, cnt=0, `gate_en`=0, `ack`=0, `busy`=0. The latch is asynchronously cleared, so `clk_out`=0 immediately.
  - If `test_pin`=1, `clk_out` resumes following `clk_in` from the next low phase.
  - Reset mid-WAKE/ON/HOLD truncates the current high phase. This is the only permitted clk_out glitch.
- Request at edge E0 (OFF, `req`=1):
  - `gate_en` rises after E0 and `clk_out` rises first at E1.
  - `ack` rises after edge E(WAKE_CYCLES), so exactly WAKE_CYCLES gated rising edges have been delivered when `ack` is first seen high.
- Release at edge R0 (ON, `req`=0):
  - `ack` falls after R0.
  - `gate_en` falls after R(IDLE_CYCLES).
  - The last `clk_out` rising edge is R(IDLE_CYCLES), giving IDLE_CYCLES edges after R0.
- Re-request in HOLD: `ack` returns after one edge, and `clk_out` is never interrupted.
- `req` toggling within a single cycle is not sampled. Only rising-edge samples matter.

## Test plan
- Reset/idle: rst_n=0 with req=4'hF → ack=0, busy=0, clk_out=0; after release with req=0 for 20 cycles → clk_out stays 0.
- Wake: ch0 req=1 at E0 (WAKE=2) → clk_out[0] rises at E1 and E2, ack[0]=1 after E2, busy=1 after E0, other channels silent.
- Idle hysteresis: ch1 in ON, req drops at R0 (IDLE=8) → ack[1]=0 after R0, exactly 8 further clk_out[1] rising edges, then gated; busy=0 after R8.
- HOLD re-request: ch2 req drops at R0 and rises at R3 → ack[2]=1 after R3, no missing clk_out[2] edge, no wake delay.
- Wake abort attempt: ch3 req high at E0 and low at E1 → channel completes WAKE, enters HOLD at E2 with ack never 1, gated after E2+8 edges.
- test_pin and reset mid-op: test_pin=1 with all req=0 → all clk_out toggle, ack=0, busy=0; assert rst_n while ch0 in ON → ack[0]=0 and clk_out[0]=0 immediately with test_pin=0; check with a glitch monitor that there are no clk_out pulses shorter than half a period except at reset assertion.
